// File: rtl/receiver_manager.sv
// receiver_manager: receive-side frame sequencer.
// Takes one encrypted frame from the AXI slave and has the ChaCha core decrypt
// it. It then checks the recovered frame counter and auth tag. A good frame
// goes to the AXI master and advances the counter and hash-chain key. A bad
// frame is dropped and signalled by a one-cycle auth_err pulse.
// Optional build macro: RX_ERR_CNT_EN adds manager2ctrl_err_cnt, a saturating
// count of dropped frames.
module receiver_manager #(
   parameter int PLAINTEXT_WIDTH          = 488,
   parameter int FRAMED_DATA_WIDTH        = 512,
   parameter int FRAMER_CNTR_WIDTH        = 16,
   parameter int FRAMER_AUTH_WIDTH        = 8,
   parameter int CHACHA_KEY_WIDTH         = 256,
   parameter int CHACHA_NONCE_WIDTH       = 96,
   parameter int CHACHA_BLOCK_COUNT_WIDTH = 32,
   parameter logic [CHACHA_NONCE_WIDTH-1:0] NONCE       = '0,
   parameter logic [CHACHA_KEY_WIDTH-1:0]   INIT_HC_KEY = '0,
   parameter int STATE_BITS_WIDTH         = 3
) (
   input  logic                                clk,
   input  logic                                resetN,
   input  logic [FRAMED_DATA_WIDTH-1:0]        slave2manager_encrypted_data,
   input  logic                                slave2manager_valid,
   output logic                                manager2slave_ready,
   output logic [PLAINTEXT_WIDTH-1:0]          manager2master_plaintext_data,
   output logic                                manager2master_valid,
   input  logic                                master2manager_ready,
   input  logic [CHACHA_KEY_WIDTH-1:0]         keygen2manager_key,
   input  logic [FRAMER_AUTH_WIDTH-1:0]        keygen2manager_auth_tag,
   output logic [CHACHA_KEY_WIDTH-1:0]         manager2keygen_HC_key,
   input  logic [FRAMED_DATA_WIDTH-1:0]        chacha2manager_encrypted_msg,
   input  logic                                chacha2manager_ready,
   input  logic                                chacha2manager_valid,
   output logic [CHACHA_KEY_WIDTH-1:0]         manager2chacha_key,
   output logic [CHACHA_NONCE_WIDTH-1:0]       manager2chacha_nonce,
   output logic                                manager2chacha_start,
   output logic [FRAMED_DATA_WIDTH-1:0]        manager2chacha_framed_plaintext,
   output logic [CHACHA_BLOCK_COUNT_WIDTH-1:0] manager2chacha_block_count,
   output logic                                manager2ctrl_auth_err
`ifdef RX_ERR_CNT_EN
   ,
   output logic [15:0]                         manager2ctrl_err_cnt
`endif
);

   typedef enum logic [STATE_BITS_WIDTH-1:0] {
      S_IDLE  = 'd0,
      S_START = 'd1,
      S_WAIT  = 'd2,
      S_CHECK = 'd3,
      S_SEND  = 'd4
   } state_t;

   // Decrypted frame: plaintext on top, then the counter, then the auth tag.
   typedef struct packed {
      logic [PLAINTEXT_WIDTH-1:0]   plaintext;
      logic [FRAMER_CNTR_WIDTH-1:0] cntr;
      logic [FRAMER_AUTH_WIDTH-1:0] tag;
   } frame_t;

   state_t                         state, state_nxt;
   logic                           ready_q;
   logic [FRAMED_DATA_WIDTH-1:0]   cipher_q;
   frame_t                         msg_q;
   logic [FRAMER_CNTR_WIDTH-1:0]   exp_cnt;
   logic [CHACHA_KEY_WIDTH-1:0]    hc_key;
   logic                           auth_err_q;

   logic                           accept;
   logic                           frame_ok;
   logic                           chk_pass;
   logic                           chk_fail;
   logic                           chacha_start;
   logic                           master_valid;

   // ready_q only goes high in IDLE, so this also qualifies the slave handshake.
   assign accept   = slave2manager_valid && ready_q;
   assign frame_ok = (msg_q.cntr == exp_cnt) && (msg_q.tag == keygen2manager_auth_tag);

   // State register; reset drops any in-flight frame.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state and per-state strobes.
   always_comb begin
      state_nxt    = state;
      chacha_start = 1'b0;
      master_valid = 1'b0;
      chk_pass     = 1'b0;
      chk_fail     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_START;
         end
         S_START: begin
            chacha_start = 1'b1;
            if (chacha2manager_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (chacha2manager_valid) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (frame_ok) begin
               chk_pass  = 1'b1;
               state_nxt = S_SEND;
            end else begin
               chk_fail  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_SEND: begin
            master_valid = 1'b1;
            if (master2manager_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Registered slave ready: low throughout reset, then tracks "next state is IDLE".
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) ready_q <= 1'b0;
      else         ready_q <= (state_nxt == S_IDLE);
   end

   // Capture the ciphertext on the slave handshake; it feeds ChaCha's XOR input.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)     cipher_q <= '0;
      else if (accept) cipher_q <= slave2manager_encrypted_data;
   end

   // Capture the decrypted frame; a valid outside WAIT is ignored.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                                     msg_q <= '0;
      else if (state == S_WAIT && chacha2manager_valid) msg_q <= frame_t'(chacha2manager_encrypted_msg);
   end

   // Accepted frames advance the counter (wrapping) and ratchet the hash-chain key.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         exp_cnt <= '0;
         hc_key  <= INIT_HC_KEY;
      end else if (chk_pass) begin
         exp_cnt <= exp_cnt + {{(FRAMER_CNTR_WIDTH-1){1'b0}}, 1'b1};
         hc_key  <= keygen2manager_key;
      end
   end

   // One-cycle drop indication, registered from the failing CHECK cycle.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) auth_err_q <= 1'b0;
      else         auth_err_q <= chk_fail;
   end

`ifdef RX_ERR_CNT_EN
   logic [15:0] err_cnt;

   // Saturating count of dropped frames.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                        err_cnt <= '0;
      else if (chk_fail && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
   end

   assign manager2ctrl_err_cnt = err_cnt;
`endif

   assign manager2slave_ready             = ready_q;
   assign manager2master_plaintext_data   = msg_q.plaintext;
   assign manager2master_valid            = master_valid;
   assign manager2keygen_HC_key           = hc_key;
   assign manager2chacha_key              = keygen2manager_key;
   assign manager2chacha_nonce            = NONCE;
   assign manager2chacha_start            = chacha_start;
   assign manager2chacha_framed_plaintext = cipher_q;
   assign manager2chacha_block_count      = {{(CHACHA_BLOCK_COUNT_WIDTH-FRAMER_CNTR_WIDTH){1'b0}}, exp_cnt};
   assign manager2ctrl_auth_err           = auth_err_q;

endmodule

// File: tb/tb_receiver_manager.sv
// tb_receiver_manager: directed frames with a scoreboard of expected outcomes
// (forwarded plaintext or drop); a monitor pops on each master handshake or
// auth_err pulse.
module tb_receiver_manager;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [511:0]  s_data;
   logic          s_valid;
   logic          s_ready;
   logic [487:0]  m_data;
   logic          m_valid;
   logic          m_ready;
   logic [255:0]  kg_key;
   logic [7:0]    kg_tag;
   logic [255:0]  hc_key;
   logic [511:0]  c_msg;
   logic          c_ready;
   logic          c_valid;
   logic [255:0]  c_key;
   logic [95:0]   c_nonce;
   logic          c_start;
   logic [511:0]  c_fp;
   logic [31:0]   c_bc;
   logic          auth_err;
`ifdef RX_ERR_CNT_EN
   logic [15:0]   err_cnt;
`endif

   typedef struct packed {
      logic         drop;
      logic [487:0] pt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   receiver_manager dut (
      .clk                             (clk),
      .resetN                          (rst_n),
      .slave2manager_encrypted_data    (s_data),
      .slave2manager_valid             (s_valid),
      .manager2slave_ready             (s_ready),
      .manager2master_plaintext_data   (m_data),
      .manager2master_valid            (m_valid),
      .master2manager_ready            (m_ready),
      .keygen2manager_key              (kg_key),
      .keygen2manager_auth_tag         (kg_tag),
      .manager2keygen_HC_key           (hc_key),
      .chacha2manager_encrypted_msg    (c_msg),
      .chacha2manager_ready            (c_ready),
      .chacha2manager_valid            (c_valid),
      .manager2chacha_key              (c_key),
      .manager2chacha_nonce            (c_nonce),
      .manager2chacha_start            (c_start),
      .manager2chacha_framed_plaintext (c_fp),
      .manager2chacha_block_count      (c_bc),
      .manager2ctrl_auth_err           (auth_err)
`ifdef RX_ERR_CNT_EN
      ,
      .manager2ctrl_err_cnt            (err_cnt)
`endif
   );

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   task automatic push_exp(input logic drop, input logic [487:0] pt);
      exp_t e;
      e.drop = drop;
      e.pt   = pt;
      sb.push_back(e);
   endtask

   // Wait for slave ready, then present one frame for a single cycle.
   task automatic accept(input logic [511:0] data);
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (s_ready) begin ok = 1; break; end
      end
      if (!ok) timeout("slave_ready");
      s_data  = data;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Wait for start, check what is presented to ChaCha, then ack it.
   task automatic chacha_ack(input logic [511:0] data, input logic [31:0] exp_bc);
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (c_start) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) timeout("chacha_start");
      check("block_count", c_bc, exp_bc);
      check("framed_plaintext", c_fp, data);
      check("chacha_key", c_key, kg_key);
      check("slave_ready_busy", s_ready, 1'b0);
      c_ready = 1'b1;
      @(negedge clk);
      c_ready = 1'b0;
   endtask

   task automatic chacha_resp(input logic [511:0] resp);
      c_msg   = resp;
      c_valid = 1'b1;
      @(negedge clk);
      c_valid = 1'b0;
   endtask

   task automatic frame(input logic [511:0] data, input logic [511:0] resp, input logic [31:0] exp_bc);
      accept(data);
      chacha_ack(data, exp_bc);
      chacha_resp(resp);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (s_ready) begin ok = 1; break; end
      end
      if (!ok) timeout("return_to_idle");
   endtask

   // Scoreboard monitor, sampled between negedge-driven stimulus and the next posedge.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_output: got plaintext %0h with no expectation", m_data);
            end else begin
               e = sb.pop_front();
               check("output_not_drop", e.drop, 1'b0);
               check("plaintext", m_data, e.pt);
            end
         end
         if (auth_err) begin
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_auth_err: got pulse with no expectation");
            end else begin
               e = sb.pop_front();
               check("drop_expected", e.drop, 1'b1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      s_data  = '0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      kg_key  = 256'h6;
      kg_tag  = 8'hE4;
      c_msg   = '0;
      c_ready = 1'b0;
      c_valid = 1'b0;

      // Reset state
      #3;
      check("rst_slave_ready", s_ready, 1'b0);
      check("rst_master_valid", m_valid, 1'b0);
      check("rst_start", c_start, 1'b0);
      check("rst_auth_err", auth_err, 1'b0);
      check("rst_hc_key", hc_key, 256'h0);
      check("rst_block_count", c_bc, 32'h0);
      check("rst_nonce", c_nonce, 96'h0);
      check("rst_chacha_key", c_key, kg_key);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("slave_ready_after_rst", s_ready, 1'b1);

      // Good frame, counter 0
      push_exp(1'b0, 488'h3);
      frame(512'hA1, 512'h30000E4, 32'h0);
      wait_idle();
      check("hc_key_f1", hc_key, 256'h6);
      check("exp_cnt_f1", c_bc, 32'h1);

      // Good frame, counter 1, new key
      kg_key = 256'h7;
      push_exp(1'b0, 488'h2);
      frame(512'hA2, 512'h20001E4, 32'h1);
      wait_idle();
      check("hc_key_f2", hc_key, 256'h7);
      check("exp_cnt_f2", c_bc, 32'h2);

      // Replayed counter 0 -> drop
      kg_key = 256'h8;
      push_exp(1'b1, '0);
      frame(512'hA3, 512'h30000E4, 32'h2);
      wait_idle();
      check("hc_key_replay", hc_key, 256'h7);
      check("exp_cnt_replay", c_bc, 32'h2);

      // Tag mismatch -> drop
      kg_tag = 8'hED;
      push_exp(1'b1, '0);
      frame(512'hA4, 512'h20002E4, 32'h2);
      wait_idle();
      check("hc_key_badtag", hc_key, 256'h7);
      check("exp_cnt_badtag", c_bc, 32'h2);
      kg_tag = 8'hE4;

      // Backpressure in SEND
      m_ready = 1'b0;
      push_exp(1'b0, 488'h5);
      frame(512'hA5, 512'h50002E4, 32'h2);
      begin
         bit ok = 0;
         for (int i = 0; i < 10; i++) begin
            if (m_valid) begin ok = 1; break; end
            @(negedge clk);
         end
         if (!ok) timeout("master_valid");
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", m_valid, 1'b1);
         check("bp_data", m_data, 488'h5);
         check("bp_slave_ready", s_ready, 1'b0);
         @(negedge clk);
      end
      m_ready = 1'b1;
      wait_idle();
      check("hc_key_bp", hc_key, 256'h8);
      check("exp_cnt_bp", c_bc, 32'h3);

      // Counter wrap
      force dut.exp_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.exp_cnt;
      @(negedge clk);
      check("exp_cnt_forced", c_bc, 32'hFFFF);
      push_exp(1'b0, 488'h9);
      frame(512'hA6, 512'h9FFFFE4, 32'hFFFF);
      wait_idle();
      check("exp_cnt_wrap", c_bc, 32'h0);
      push_exp(1'b0, 488'hA);
      frame(512'hA7, 512'hA0000E4, 32'h0);
      wait_idle();
      check("exp_cnt_after_wrap", c_bc, 32'h1);

      // Reset while waiting for ChaCha
      kg_key = 256'h9;
      accept(512'hA8);
      chacha_ack(512'hA8, 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_slave_ready", s_ready, 1'b0);
      check("midrst_start", c_start, 1'b0);
      check("midrst_master_valid", m_valid, 1'b0);
      check("midrst_exp_cnt", c_bc, 32'h0);
      check("midrst_hc_key", hc_key, 256'h0);
      check("midrst_framed", c_fp, 512'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready_back", s_ready, 1'b1);

      // Three bad-tag frames
      for (int k = 0; k < 3; k++) begin
         push_exp(1'b1, '0);
         frame(512'hB0 + 512'(k), 512'h1000011, 32'h0);
         wait_idle();
      end
      check("bad3_exp_cnt", c_bc, 32'h0);
      check("bad3_hc_key", hc_key, 256'h0);
`ifdef RX_ERR_CNT_EN
      check("err_cnt", err_cnt, 16'd3);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/receiver_manager.md
# receiver_manager

Receive-side control block, downstream of the transmitter manager across the link. It accepts one 512-bit encrypted frame from the AXI slave and drives the ChaCha core to decrypt it with the current key. It then checks the recovered frame counter and auth tag, and either forwards the 488-bit plaintext to the AXI master or drops the frame. On every accepted frame it advances the frame counter and ratchets the hash-chain key toward the key generator.

## Interface
- PLAINTEXT_WIDTH, 488, plaintext payload bits
- FRAMED_DATA_WIDTH, 512, framed/encrypted frame bits
- FRAMER_CNTR_WIDTH, 16, frame counter field bits
- FRAMER_AUTH_WIDTH, 8, auth tag field bits
- CHACHA_KEY_WIDTH, 256, key bits
- CHACHA_NONCE_WIDTH, 96, nonce bits
- CHACHA_BLOCK_COUNT_WIDTH, 32, block count bits
- NONCE, 96'h0, constant nonce driven to ChaCha
- INIT_HC_KEY, 256'h0, hash-chain key after reset
- STATE_BITS_WIDTH, 3, FSM state register width

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetN  in  1  asynchronous, active-low reset
- slave2manager_encrypted_data  in  512  encrypted frame
- slave2manager_valid  in  1  frame valid
- manager2slave_ready  out  1  frame accept
- manager2master_plaintext_data  out  488  recovered plaintext
- manager2master_valid  out  1  plaintext valid
- master2manager_ready  in  1  downstream accept
- keygen2manager_key  in  256  ChaCha key derived from HC key
- keygen2manager_auth_tag  in  8  expected auth tag
- manager2keygen_HC_key  out  256  current hash-chain key
- chacha2manager_encrypted_msg  in  512  ChaCha output (decrypted frame)
- chacha2manager_ready  in  1  ChaCha accepted start (1-cycle pulse)
- chacha2manager_valid  in  1  ChaCha result valid (1-cycle pulse)
- manager2chacha_key  out  256  key
- manager2chacha_nonce  out  96  nonce
- manager2chacha_start  out  1  start request
- manager2chacha_framed_plaintext  out  512  data to XOR (the captured ciphertext)
- manager2chacha_block_count  out  32  block count
- manager2ctrl_auth_err  out  1  1-cycle pulse on dropped frame

## Operation
- Decrypted frame layout: [511:24] plaintext, [23:8] counter, [7:0] auth tag.
- FSM states:
  - IDLE: ready=1. On valid&&ready, capture the data and go to START.
  - START: start=1, held until chacha2manager_ready, then go to WAIT.
  - WAIT: on chacha2manager_valid, capture encrypted_msg and go to CHECK.
  - CHECK: pass if counter field == exp_cnt AND tag field == keygen2manager_auth_tag. Pass goes to SEND; fail drops the frame and goes to IDLE.
  - SEND: master_valid=1 with the data held stable; on master2manager_ready, go to IDLE.
- manager2chacha_key = keygen2manager_key. manager2chacha_nonce = NONCE. manager2chacha_block_count = {16'h0, exp_cnt}.
- On a pass in CHECK:
  - exp_cnt increments, wrapping modulo 2^16 (16'hFFFF to 16'h0000).
  - HC key register <= keygen2manager_key.
- On a fail in CHECK:
  - auth_err pulses for 1 cycle.
  - exp_cnt and HC key are unchanged.
- manager2slave_ready is 0 in every state except IDLE; there is no buffering of a second frame.
- chacha2manager_valid outside WAIT and chacha2manager_ready outside START are ignored.

## Timing
- Reset values:
  - State IDLE; exp_cnt 0; HC key INIT_HC_KEY.
  - manager2slave_ready=0 during reset, then 1 from the first clock after release.
  - All other outputs 0, except key/nonce/HC/block_count, which follow their definitions.
- Minimum latency, with the frame accepted in cycle N and ChaCha ready in N+1 and valid in N+2:
  - CHECK in N+3.
  - manager2master_valid first high in N+4.
  - manager2slave_ready high again the cycle after master handshake.
- auth_err is asserted in the cycle after CHECK (registered).
- Reset asserted mid-operation immediately forces IDLE and clears everything. An in-flight frame is lost.
- The keygen path is combinational from manager2keygen_HC_key; the HC key changes only on CHECK pass.

## Configuration
- RX_ERR_CNT_EN:
  - Defined: adds output manager2ctrl_err_cnt [15:0], a count of dropped frames that saturates at 16'hFFFF and resets to 0.
  - Undefined: the port and counter are absent; auth_err pulse only.

## Test plan
- Key 256'h6, tag 8'he4; slave sends a frame; ChaCha returns 512'h30000E4 -> master receives 488'h3, auth_err=0, exp_cnt=1, HC key=256'h6.
- Next frame, ChaCha returns 512'h20001E4 -> plaintext 488'h2 and block_count 32'h1 during START. A second back-to-back frame returning 512'h30000E4 (counter 0, replay) -> dropped, auth_err pulse, exp_cnt stays 2.
- Tag mismatch: keygen tag changed to 8'hed, ChaCha returns 512'h20002E4 -> dropped, no master_valid, HC key unchanged.
- Backpressure: master2manager_ready held 0 for 5 cycles in SEND -> data stable, slave_ready stays 0, handshake completes on release.
- Wrap: force exp_cnt to 16'hFFFF; frame with counter FFFF passes -> exp_cnt 0; next frame with counter 0000 passes.
- Reset asserted during WAIT -> IDLE, outputs reset, exp_cnt 0. With RX_ERR_CNT_EN defined, 3 bad frames -> err_cnt=3.
